// File: rtl/compute_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one compute engine.
// It runs one transaction at a time: arbitrate, issue, wait (with timeout), respond.
module compute_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [16*NUM_REQ-1:0]    req_data_1,
   input  logic [8*NUM_REQ-1:0]     req_data_2,
   output logic [NUM_REQ-1:0]       ack,
   output logic signed [31:0]       rsp_result_1,
   output logic [15:0]              rsp_result_2,
   output logic                     rsp_error,
   output logic                     eng_start,
   output logic signed [15:0]       eng_data_1,
   output logic [7:0]               eng_data_2,
   input  logic                     eng_done,
   input  logic [31:0]              eng_result_1,
   input  logic [15:0]              eng_result_2,
   output logic                     busy,
   output logic [2:0]               grant_id
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RESPOND = 2'd3;

   localparam int              CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]      NUM_REQ_W = 4'(NUM_REQ);

   logic [1:0]       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       last_grant_reg;
   logic [2:0]       grant_id_reg;
   logic [15:0]      eng_data_1_reg;
   logic [7:0]       eng_data_2_reg;
   logic [31:0]      rsp_result_1_reg;
   logic [15:0]      rsp_result_2_reg;
   logic             rsp_error_reg;

   logic [15:0]            slot_data_1 [NUM_REQ];
   logic [7:0]             slot_data_2 [NUM_REQ];
   logic [2*NUM_REQ-1:0]   req_dbl;
   logic [3:0]             rot_shift;
   logic [NUM_REQ-1:0]     req_rot;
   logic [2:0]             rot_off;
   logic [3:0]             pick_sum;
   logic [2:0]             pick_idx;
   logic                   pick_valid;
   logic [15:0]            pick_data_1;
   logic [7:0]             pick_data_2;

   // ack is gated by rst_n so a reset during RESPOND never leaks a completion.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         assign slot_data_1[gi] = req_data_1[gi*16 +: 16];
         assign slot_data_2[gi] = req_data_2[gi*8 +: 8];
         assign ack[gi] = rst_n && (state_reg == ST_RESPOND) && (grant_id_reg == 3'(gi));
      end
   endgenerate

   // Rotate requests so bit 0 is the requester just after last_grant.
   assign req_dbl    = {req, req};
   assign rot_shift  = {1'b0, last_grant_reg} + 4'd1;
   assign req_rot    = NUM_REQ'(req_dbl >> rot_shift);
   assign pick_valid = |req;

   always_comb begin
      rot_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) rot_off = 3'(k);
      end
   end

   always_comb begin
      pick_sum = rot_shift + {1'b0, rot_off};
      if (pick_sum >= NUM_REQ_W) pick_sum = pick_sum - NUM_REQ_W;
   end

   assign pick_idx = pick_sum[2:0];

   always_comb begin
      pick_data_1 = '0;
      pick_data_2 = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == 3'(k)) begin
            pick_data_1 = slot_data_1[k];
            pick_data_2 = slot_data_2[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= '0;
         last_grant_reg   <= 3'(NUM_REQ - 1);
         grant_id_reg     <= '0;
         eng_data_1_reg   <= '0;
         eng_data_2_reg   <= '0;
         rsp_result_1_reg <= '0;
         rsp_result_2_reg <= '0;
         rsp_error_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_id_reg   <= pick_idx;
                  eng_data_1_reg <= pick_data_1;
                  eng_data_2_reg <= pick_data_2;
                  state_reg      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_reg   <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving on the final wait cycle wins over the timeout.
               if (eng_done) begin
                  rsp_result_1_reg <= eng_result_1;
                  rsp_result_2_reg <= eng_result_2;
                  rsp_error_reg    <= 1'b0;
                  state_reg        <= ST_RESPOND;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                  if (cnt_reg == CNT_LAST) begin
                     rsp_result_1_reg <= '0;
                     rsp_result_2_reg <= '0;
                     rsp_error_reg    <= 1'b1;
                     state_reg        <= ST_RESPOND;
                  end
               end
            end
            default: begin
               last_grant_reg <= grant_id_reg;
               state_reg      <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = (state_reg != ST_IDLE);
   assign eng_start    = (state_reg == ST_ISSUE);
   assign eng_data_1   = eng_data_1_reg;
   assign eng_data_2   = eng_data_2_reg;
   assign rsp_result_1 = rsp_result_1_reg;
   assign rsp_result_2 = rsp_result_2_reg;
   assign rsp_error    = rsp_error_reg;
   assign grant_id     = grant_id_reg;

endmodule

// File: tb/tb_compute_arbiter.sv
// Bench for compute_arbiter: scenario tasks plus randomized transactions
// checked against a transaction-level round-robin/timeout model.
module tb_compute_arbiter;

   localparam int N  = 4;
   localparam int TO = 15;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [16*N-1:0] req_data_1;
   logic [8*N-1:0]  req_data_2;
   logic [N-1:0]    ack;
   logic [31:0]     rsp_result_1;
   logic [15:0]     rsp_result_2;
   logic            rsp_error;
   logic            eng_start;
   logic [15:0]     eng_data_1;
   logic [7:0]      eng_data_2;
   logic            eng_done;
   logic [31:0]     eng_result_1;
   logic [15:0]     eng_result_2;
   logic            busy;
   logic [2:0]      grant_id;

   int total = 0;
   int bad   = 0;
   int model_last;

   always #5 clk = ~clk;

   compute_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .req_data_1(req_data_1), .req_data_2(req_data_2),
      .ack(ack), .rsp_result_1(rsp_result_1), .rsp_result_2(rsp_result_2),
      .rsp_error(rsp_error), .eng_start(eng_start),
      .eng_data_1(eng_data_1), .eng_data_2(eng_data_2),
      .eng_done(eng_done), .eng_result_1(eng_result_1), .eng_result_2(eng_result_2),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; req = '0; eng_done = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      model_last = N - 1;
   endtask

   task automatic rand_data;
      for (int i = 0; i < N; i++) begin
         req_data_1[i*16 +: 16] = 16'($urandom);
         req_data_2[i*8 +: 8]   = 8'($urandom);
      end
   endtask

   // Round-robin rule: first requester set, searching upward from last grant + 1.
   function automatic int model_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Runs one transaction from IDLE; the engine raises done in the delay-th WAIT cycle (0 = never).
   task automatic do_txn(
      input  logic [N-1:0] req_init, input logic [N-1:0] req_after_grant,
      input  logic [N-1:0] req_after_ack, input int delay, input bit spurious,
      input  logic [31:0] er1, input logic [15:0] er2,
      output bit started, output int start_lat, output logic [2:0] gid,
      output logic [15:0] d1, output logic [7:0] d2, output logic [15:0] d1_late,
      output logic [N-1:0] ackv, output logic [31:0] r1, output logic [15:0] r2,
      output logic err, output int ack_lat, output logic [N-1:0] ack_after,
      output logic busy_after);
      req = req_init; eng_done = 1'b0;
      started = 0; start_lat = -1; ack_lat = -1; gid = '0; d1 = '0; d2 = '0;
      d1_late = '0; ackv = '0; r1 = '0; r2 = '0; err = 1'b0; ack_after = '0; busy_after = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick;
         if (eng_start) begin started = 1; start_lat = c; break; end
      end
      if (!started) return;
      gid = grant_id; d1 = eng_data_1; d2 = eng_data_2;
      req = req_after_grant;
      eng_done = spurious; eng_result_1 = $urandom; eng_result_2 = 16'($urandom);
      for (int c = 1; c <= TO + 5; c++) begin
         tick;
         if (ack != '0) begin
            ackv = ack; r1 = rsp_result_1; r2 = rsp_result_2; err = rsp_error; ack_lat = c;
            break;
         end
         d1_late = eng_data_1;
         eng_done = (c == delay);
         eng_result_1 = (c == delay) ? er1 : $urandom;
         eng_result_2 = (c == delay) ? er2 : 16'($urandom);
      end
      eng_done = 1'b0;
      req = req_after_ack;
      tick;
      ack_after = ack; busy_after = busy;
      $display("txn grant=%0d ack=%b r1=%08h r2=%04h err=%0b start_lat=%0d ack_lat=%0d",
               gid, ackv, r1, r2, err, start_lat, ack_lat);
   endtask

   bit st; int sl, al; logic [2:0] g; logic [15:0] d1, d1l; logic [7:0] d2;
   logic [N-1:0] av, aa; logic [31:0] r1; logic [15:0] r2; logic er, ba;

   task automatic test_reset;
      rst_n = 1'b0; req = '1; eng_done = 1'b1; rand_data;
      tick; tick;
      total++; if (ack !== '0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", eng_start); end
      total++; if (rsp_result_1 !== '0) begin bad++; $display("FAIL reset_r1 got=%h exp=0", rsp_result_1); end
      total++; if (rsp_result_2 !== '0) begin bad++; $display("FAIL reset_r2 got=%h exp=0", rsp_result_2); end
      total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rsp_error); end
      total++; if (eng_data_1 !== '0 || eng_data_2 !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", eng_data_1, eng_data_2); end
      total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
      rst_n = 1'b1; req = '0; eng_done = 1'b0;
      tick;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
      model_last = N - 1;
   endtask

   task automatic test_single;
      do_reset; rand_data;
      req_data_1[2*16 +: 16] = 16'hFFFD;
      req_data_2[2*8 +: 8]   = 8'd5;
      do_txn(4'b0100, 4'b0100, 4'b0000, 1, 0, 32'd9, 16'd10, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (sl !== 1) begin bad++; $display("FAIL single_start_lat got=%0d exp=1", sl); end
      total++; if (g !== 3'd2) begin bad++; $display("FAIL single_gid got=%0d exp=2", g); end
      total++; if (d1 !== 16'hFFFD || d2 !== 8'd5) begin bad++; $display("FAIL single_operands got=%h/%h exp=fffd/05", d1, d2); end
      total++; if (av !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", av); end
      total++; if (r1 !== 32'd9 || r2 !== 16'd10) begin bad++; $display("FAIL single_results got=%0d/%0d exp=9/10", r1, r2); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", er); end
      total++; if (al !== 2) begin bad++; $display("FAIL single_ack_lat got=%0d exp=2", al); end
      total++; if (aa !== '0 || ba !== 1'b0) begin bad++; $display("FAIL single_after got=%b/%b exp=0/0", aa, ba); end
      model_last = 2;
   endtask

   task automatic test_round_robin;
      int dl; logic [31:0] e1; logic [15:0] e2; logic [N-1:0] expa;
      do_reset;
      for (int t = 0; t < 5; t++) begin
         rand_data; dl = int'($urandom_range(1, 4)); e1 = $urandom; e2 = 16'($urandom);
         expa = N'(1 << (t % N));
         do_txn(4'hF, 4'hF, 4'hF, dl, 0, e1, e2, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
         total++; if (g !== 3'(t % N)) begin bad++; $display("FAIL rr_gid t=%0d got=%0d exp=%0d", t, g, t % N); end
         total++; if (av !== expa) begin bad++; $display("FAIL rr_ack t=%0d got=%b exp=%b", t, av, expa); end
         total++; if (r1 !== e1 || r2 !== e2 || er !== 1'b0) begin bad++; $display("FAIL rr_result t=%0d got=%h/%h/%b exp=%h/%h/0", t, r1, r2, er, e1, e2); end
         total++; if (d1 !== req_data_1[(t%N)*16 +: 16]) begin bad++; $display("FAIL rr_data1 t=%0d got=%h exp=%h", t, d1, req_data_1[(t%N)*16 +: 16]); end
         total++; if (al !== dl + 1 || aa !== '0) begin bad++; $display("FAIL rr_timing t=%0d got=%0d/%b exp=%0d/0", t, al, aa, dl + 1); end
      end
      req = '0;
      model_last = 0;
   endtask

   task automatic test_timeout;
      do_reset; rand_data;
      do_txn(4'b0001, 4'b0001, 4'b0000, 2, 0, 32'hDEAD_BEEF, 16'h1234, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (r1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_prime got=%h exp=deadbeef", r1); end
      do_txn(4'b0010, 4'b0010, 4'b0000, 0, 0, 32'h0, 16'h0, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd1 || av !== 4'b0010) begin bad++; $display("FAIL to_grant got=%0d/%b exp=1/0010", g, av); end
      total++; if (al !== TO + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", al, TO + 1); end
      total++; if (er !== 1'b1 || r1 !== '0 || r2 !== '0) begin bad++; $display("FAIL to_result got=%b/%h/%h exp=1/0/0", er, r1, r2); end
      total++; if (d1l !== d1) begin bad++; $display("FAIL to_operand_hold got=%h exp=%h", d1l, d1); end
      model_last = 1;
   endtask

   task automatic test_done_at_limit;
      logic [31:0] e1; logic [15:0] e2;
      e1 = $urandom; e2 = 16'($urandom); rand_data;
      do_txn(4'b0100, 4'b0000, 4'b0000, TO, 1, e1, e2, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd2) begin bad++; $display("FAIL limit_gid got=%0d exp=2", g); end
      total++; if (al !== TO + 1) begin bad++; $display("FAIL limit_latency got=%0d exp=%0d", al, TO + 1); end
      total++; if (er !== 1'b0 || r1 !== e1 || r2 !== e2) begin bad++; $display("FAIL limit_result got=%b/%h/%h exp=0/%h/%h", er, r1, r2, e1, e2); end
      model_last = 2;
   endtask

   task automatic test_reset_in_wait;
      bit saw_ack;
      do_reset; rand_data;
      req = 4'b1000;
      tick;
      total++; if (eng_start !== 1'b1 || grant_id !== 3'd3) begin bad++; $display("FAIL rw_issue got=%b/%0d exp=1/3", eng_start, grant_id); end
      saw_ack = 0;
      tick; saw_ack |= (ack != '0);
      tick; saw_ack |= (ack != '0);
      rst_n = 1'b0; eng_done = 1'b1;
      tick; saw_ack |= (ack != '0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rw_busy got=%b exp=0", busy); end
      total++; if (saw_ack) begin bad++; $display("FAIL rw_no_ack got=1 exp=0"); end
      rst_n = 1'b1; eng_done = 1'b0; model_last = N - 1;
      do_txn(4'hF, 4'hF, 4'h0, 1, 0, 32'h5, 16'h6, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd0 || av !== 4'b0001) begin bad++; $display("FAIL rw_first_grant got=%0d/%b exp=0/0001", g, av); end
      model_last = 0;
   endtask

   task automatic test_drop;
      logic [31:0] held;
      do_reset; rand_data;
      do_txn(4'b0100, 4'b1010, 4'b1010, 3, 0, 32'h77, 16'h88, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd2 || av !== 4'b0100) begin bad++; $display("FAIL drop_ack got=%0d/%b exp=2/0100", g, av); end
      total++; if (al !== 4 || r1 !== 32'h77) begin bad++; $display("FAIL drop_result got=%0d/%h exp=4/77", al, r1); end
      do_txn(4'b1010, 4'b0010, 4'b0010, 2, 0, 32'h99, 16'hAA, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd3) begin bad++; $display("FAIL drop_next_gid got=%0d exp=3", g); end
      do_txn(4'b0010, 4'b0000, 4'b0000, 1, 0, 32'hABCD, 16'h1, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
      total++; if (g !== 3'd1) begin bad++; $display("FAIL drop_third_gid got=%0d exp=1", g); end
      held = r1;
      eng_done = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         total++; if (busy !== 1'b0 || ack !== '0 || eng_start !== 1'b0 || rsp_result_1 !== held || grant_id !== 3'd1) begin
            bad++; $display("FAIL idle_hold c=%0d got=%b/%b/%b/%h/%0d exp=0/0/0/%h/1", c, busy, ack, eng_start, rsp_result_1, grant_id, held);
         end
      end
      eng_done = 1'b0;
      model_last = 1;
   endtask

   task automatic test_random;
      logic [N-1:0] rv; int dl, eg; bit ok; logic [31:0] e1, x1; logic [15:0] e2, x2;
      do_reset;
      for (int t = 0; t < 30; t++) begin
         rand_data;
         rv = N'($urandom_range(1, (1 << N) - 1));
         dl = int'($urandom_range(0, TO + 2));
         e1 = $urandom; e2 = 16'($urandom);
         eg = model_pick(rv, model_last);
         ok = (dl >= 1 && dl <= TO);
         x1 = ok ? e1 : 32'h0; x2 = ok ? e2 : 16'h0;
         do_txn(rv, N'($urandom), 4'h0, dl, bit'($urandom_range(0, 1)), e1, e2, st, sl, g, d1, d2, d1l, av, r1, r2, er, al, aa, ba);
         total++; if (!st || g !== 3'(eg)) begin bad++; $display("FAIL rnd_gid t=%0d got=%0d exp=%0d", t, g, eg); end
         total++; if (av !== N'(1 << eg)) begin bad++; $display("FAIL rnd_ack t=%0d got=%b exp=%b", t, av, N'(1 << eg)); end
         total++; if (d1 !== req_data_1[eg*16 +: 16] || d2 !== req_data_2[eg*8 +: 8]) begin bad++; $display("FAIL rnd_operands t=%0d got=%h/%h exp=%h/%h", t, d1, d2, req_data_1[eg*16 +: 16], req_data_2[eg*8 +: 8]); end
         total++; if (r1 !== x1 || r2 !== x2 || er !== !ok) begin bad++; $display("FAIL rnd_result t=%0d got=%h/%h/%b exp=%h/%h/%b", t, r1, r2, er, x1, x2, !ok); end
         total++; if (al !== (ok ? dl + 1 : TO + 1)) begin bad++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, al, ok ? dl + 1 : TO + 1); end
         total++; if (aa !== '0 || ba !== 1'b0) begin bad++; $display("FAIL rnd_after t=%0d got=%b/%b exp=0/0", t, aa, ba); end
         model_last = eg;
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; eng_done = 1'b0; eng_result_1 = '0; eng_result_2 = '0;
      req_data_1 = '0; req_data_2 = '0;
      test_reset;
      test_single;
      test_round_robin;
      test_timeout;
      test_done_at_limit;
      test_reset_in_wait;
      test_drop;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
